preprocess_control: RTL and testbench

- Tracks word position within each packet on the router-port ingress datapath.
- Emits single-cycle, word-aligned strobes that tell eth_parser and the downstream IP parsers (checksum, TTL, dst lookup) which header field is on in_data.
- Sits beside the input FIFO read side and observes the same in_data/in_ctrl/in_wr the parsers see. Never stalls or modifies the stream.

---
 rtl/preprocess_control.sv | 133 +++++++++++++
 tb/tb_preprocess_control.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/preprocess_control.sv
// Ingress header-word tracker: raises zero-latency strobes
// naming the header field present on in_data each cycle.
module preprocess_control #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  word_MAC_DA_HI,
  output logic                  word_MAC_DASA,
  output logic                  word_ETH_IP_VER,
  output logic                  word_IP_LEN_ID,
  output logic                  word_IP_FRAG_TTL_PROTO,
  output logic                  word_IP_CHECKSUM_SRC_HI,
  output logic                  word_IP_SRC_DST,
  output logic                  word_IP_DST_LO,
  output logic                  short_pkt
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $fatal(1, "preprocess_control: DATA_WIDTH must be 32 or 64");
  end

  localparam bit IS64 = (DATA_WIDTH == 64);

  localparam logic [3:0] I_DA_HI = 4'd0;
  localparam logic [3:0] I_DASA  = IS64 ? 4'd0 : 4'd1;
  localparam logic [3:0] I_ETH   = IS64 ? 4'd1 : 4'd3;
  localparam logic [3:0] I_LEN   = IS64 ? 4'd2 : 4'd4;
  localparam logic [3:0] I_FRAG  = IS64 ? 4'd2 : 4'd5;
  localparam logic [3:0] I_CK    = IS64 ? 4'd3 : 4'd6;
  localparam logic [3:0] I_SD    = IS64 ? 4'd3 : 4'd7;
  localparam logic [3:0] I_LAST  = IS64 ? 4'd4 : 4'd8;

  typedef enum logic [1:0] {
    SKIP_HDRS,
    IN_HDR,
    WAIT_EOP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] idx;
  logic       hit;
  logic       short_d;
  logic       data_w;
  logic       ctrl_w;

  // The datapath is only observed; strobes depend on position alone.
  logic unused_data;
  assign unused_data = ^in_data;

  assign data_w = in_wr & ~(|in_ctrl);
  assign ctrl_w = in_wr & (|in_ctrl);

  // State and word-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SKIP_HDRS;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, current word index and short-packet detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx     = cnt_q;
    hit     = 1'b0;
    short_d = 1'b0;
    unique case (state_q)
      SKIP_HDRS: begin
        if (data_w) begin
          hit     = 1'b1;
          idx     = 4'd0;
          cnt_d   = 4'd1;
          state_d = IN_HDR;
        end
      end
      IN_HDR: begin
        if (data_w) begin
          hit   = 1'b1;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == I_LAST) state_d = WAIT_EOP;
        end else if (ctrl_w) begin
          short_d = 1'b1;
          cnt_d   = 4'd0;
          state_d = SKIP_HDRS;
        end
      end
      WAIT_EOP: begin
        if (ctrl_w) begin
          cnt_d   = 4'd0;
          state_d = SKIP_HDRS;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = SKIP_HDRS;
      end
    endcase
  end

  // Field strobes, held low throughout reset.
  always_comb begin
    word_MAC_DA_HI          = 1'b0;
    word_MAC_DASA           = 1'b0;
    word_ETH_IP_VER         = 1'b0;
    word_IP_LEN_ID          = 1'b0;
    word_IP_FRAG_TTL_PROTO  = 1'b0;
    word_IP_CHECKSUM_SRC_HI = 1'b0;
    word_IP_SRC_DST         = 1'b0;
    word_IP_DST_LO          = 1'b0;
    short_pkt               = short_d & ~reset;
    if (hit && !reset) begin
      word_MAC_DA_HI          = (idx == I_DA_HI);
      word_MAC_DASA           = (idx == I_DASA);
      word_ETH_IP_VER         = (idx == I_ETH);
      word_IP_LEN_ID          = (idx == I_LEN);
      word_IP_FRAG_TTL_PROTO  = (idx == I_FRAG);
      word_IP_CHECKSUM_SRC_HI = (idx == I_CK);
      word_IP_SRC_DST         = (idx == I_SD);
      word_IP_DST_LO          = (idx == I_LAST);
    end
  end

endmodule

// File: tb/tb_preprocess_control.sv
// Directed bench for preprocess_control: 64-bit and 32-bit
// instances driven word by word against hand-derived strobes.
module tb_preprocess_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_data;
  logic [7:0]  a_ctrl;
  logic        a_wr;
  logic [31:0] b_data;
  logic [3:0]  b_ctrl;
  logic        b_wr;

  logic [8:0] a_obs;
  logic [8:0] b_obs;

  int checks = 0;
  int errors = 0;
  int cnt[9];
  bit cnt_en = 1'b0;

  // {DA_HI, DASA, ETH, LEN, FRAG, CKSUM, SRCDST, DSTLO, short}
  localparam logic [8:0] N    = 9'b000000000;
  localparam logic [8:0] DA   = 9'b110000000;
  localparam logic [8:0] ETH  = 9'b001000000;
  localparam logic [8:0] LEN  = 9'b000110000;
  localparam logic [8:0] CK   = 9'b000001100;
  localparam logic [8:0] DST  = 9'b000000010;
  localparam logic [8:0] SH   = 9'b000000001;

  preprocess_control #(.DATA_WIDTH(64)) u_a (
    .clk                     (clk),
    .reset                   (rst),
    .in_data                 (a_data),
    .in_ctrl                 (a_ctrl),
    .in_wr                   (a_wr),
    .word_MAC_DA_HI          (a_obs[8]),
    .word_MAC_DASA           (a_obs[7]),
    .word_ETH_IP_VER         (a_obs[6]),
    .word_IP_LEN_ID          (a_obs[5]),
    .word_IP_FRAG_TTL_PROTO  (a_obs[4]),
    .word_IP_CHECKSUM_SRC_HI (a_obs[3]),
    .word_IP_SRC_DST         (a_obs[2]),
    .word_IP_DST_LO          (a_obs[1]),
    .short_pkt               (a_obs[0])
  );

  preprocess_control #(.DATA_WIDTH(32)) u_b (
    .clk                     (clk),
    .reset                   (rst),
    .in_data                 (b_data),
    .in_ctrl                 (b_ctrl),
    .in_wr                   (b_wr),
    .word_MAC_DA_HI          (b_obs[8]),
    .word_MAC_DASA           (b_obs[7]),
    .word_ETH_IP_VER         (b_obs[6]),
    .word_IP_LEN_ID          (b_obs[5]),
    .word_IP_FRAG_TTL_PROTO  (b_obs[4]),
    .word_IP_CHECKSUM_SRC_HI (b_obs[3]),
    .word_IP_SRC_DST         (b_obs[2]),
    .word_IP_DST_LO          (b_obs[1]),
    .short_pkt               (b_obs[0])
  );

  task automatic chk(string tag, logic [8:0] obs, logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sa(logic wr, logic [7:0] ctrl, logic [8:0] exp,
                    string tag);
    a_wr   = wr;
    a_ctrl = ctrl;
    a_data = {$urandom, $urandom};
    @(negedge clk);
    chk(tag, a_obs, exp);
    if (cnt_en)
      for (int i = 0; i < 9; i++) cnt[i] += int'(a_obs[i]);
    @(posedge clk);
    #1;
    a_wr = 1'b0;
  endtask

  task automatic sb(logic wr, logic [3:0] ctrl, logic [8:0] exp,
                    string tag);
    b_wr   = wr;
    b_ctrl = ctrl;
    b_data = $urandom;
    @(negedge clk);
    chk(tag, b_obs, exp);
    if (cnt_en)
      for (int i = 0; i < 9; i++) cnt[i] += int'(b_obs[i]);
    @(posedge clk);
    #1;
    b_wr = 1'b0;
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < 9; i++) cnt[i] = 0;
  endtask

  // Standard packet: header, 8 data words, EOP, optional idle gaps.
  task automatic pkt_a(int gap, string tag);
    logic [8:0] e [0:7];
    e[0] = DA; e[1] = ETH; e[2] = LEN; e[3] = CK;
    e[4] = DST; e[5] = N; e[6] = N; e[7] = N;
    sa(1'b1, 8'hFF, N, {tag, "_hdr"});
    for (int g = 0; g < gap; g++) sa(1'b0, 8'h00, N, {tag, "_gap"});
    for (int w = 0; w < 8; w++) begin
      sa(1'b1, 8'h00, e[w], $sformatf("%s_d%0d", tag, w));
      for (int g = 0; g < gap; g++) sa(1'b0, 8'h00, N, {tag, "_gap"});
    end
    sa(1'b1, 8'h80, N, {tag, "_eop"});
    for (int g = 0; g < gap; g++) sa(1'b0, 8'h00, N, {tag, "_gap"});
  endtask

  initial begin
    logic [8:0] e32 [0:15];
    rst    = 1'b1;
    a_wr   = 1'b0;
    a_ctrl = '0;
    a_data = '0;
    b_wr   = 1'b0;
    b_ctrl = '0;
    b_data = '0;
    clr_cnt();
    @(posedge clk);
    #1;

    // Outputs forced low while reset is high, even with data words.
    sa(1'b1, 8'h00, N, "rst_a0");
    sa(1'b1, 8'h00, N, "rst_a1");
    sb(1'b1, 4'h0, N, "rst_b0");
    rst = 1'b0;

    pkt_a(0, "p64");
    pkt_a(3, "gap64");

    // Short packet: two headers, two data words, EOP.
    sa(1'b1, 8'hFF, N,   "sh_h0");
    sa(1'b1, 8'hFF, N,   "sh_h1");
    sa(1'b1, 8'h00, DA,  "sh_d0");
    sa(1'b1, 8'h00, ETH, "sh_d1");
    sa(1'b1, 8'h0F, SH,  "sh_eop");
    sa(1'b1, 8'hFF, N,   "nx_hdr");
    sa(1'b1, 8'h00, DA,  "nx_d0");
    sa(1'b1, 8'h00, ETH, "nx_d1");
    sa(1'b1, 8'h00, LEN, "nx_d2");
    sa(1'b1, 8'h00, CK,  "nx_d3");
    sa(1'b1, 8'h00, DST, "nx_d4");
    sa(1'b1, 8'h80, N,   "nx_eop");

    // Reset on data word 2, then a fresh header/data sequence.
    sa(1'b1, 8'hFF, N,   "mr_hdr");
    sa(1'b1, 8'h00, DA,  "mr_d0");
    sa(1'b1, 8'h00, ETH, "mr_d1");
    rst = 1'b1;
    sa(1'b1, 8'h00, N,   "mr_rst");
    rst = 1'b0;
    sa(1'b1, 8'hFF, N,   "mr_hdr2");
    sa(1'b1, 8'h00, DA,  "mr_new0");
    sa(1'b1, 8'h00, ETH, "mr_new1");
    sa(1'b1, 8'h00, LEN, "mr_new2");
    sa(1'b1, 8'h00, CK,  "mr_new3");
    sa(1'b1, 8'h00, DST, "mr_new4");
    sa(1'b1, 8'h80, N,   "mr_eop");

    // Ten back-to-back minimum packets.
    clr_cnt();
    cnt_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      sa(1'b1, 8'hFF, N,   $sformatf("b2b%0d_h", p));
      sa(1'b1, 8'h00, DA,  $sformatf("b2b%0d_d0", p));
      sa(1'b1, 8'h00, ETH, $sformatf("b2b%0d_d1", p));
      sa(1'b1, 8'h00, LEN, $sformatf("b2b%0d_d2", p));
      sa(1'b1, 8'h00, CK,  $sformatf("b2b%0d_d3", p));
      sa(1'b1, 8'h00, DST, $sformatf("b2b%0d_d4", p));
      sa(1'b1, 8'h80, N,   $sformatf("b2b%0d_eop", p));
    end
    cnt_en = 1'b0;
    for (int i = 1; i < 9; i++)
      chk_int($sformatf("b2b_cnt%0d", i), cnt[i], 10);
    chk_int("b2b_short", cnt[0], 0);

    // 32-bit: header, 16 data words, EOP.
    for (int w = 0; w < 16; w++) e32[w] = N;
    e32[0] = 9'b100000000;
    e32[1] = 9'b010000000;
    e32[3] = 9'b001000000;
    e32[4] = 9'b000100000;
    e32[5] = 9'b000010000;
    e32[6] = 9'b000001000;
    e32[7] = 9'b000000100;
    e32[8] = 9'b000000010;
    clr_cnt();
    cnt_en = 1'b1;
    sb(1'b1, 4'hF, N, "p32_hdr");
    for (int w = 0; w < 16; w++)
      sb(1'b1, 4'h0, e32[w], $sformatf("p32_d%0d", w));
    sb(1'b1, 4'h8, N, "p32_eop");
    cnt_en = 1'b0;
    for (int i = 1; i < 9; i++)
      chk_int($sformatf("p32_cnt%0d", i), cnt[i], 1);
    chk_int("p32_short", cnt[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
